// File: rtl/fpu_pkg.sv
// Shared FPU definitions: bfloat16 format constants, divider state encoding
// and iteration count.
package fpu_pkg;

  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;
  localparam int BF16_BIAS   = (1 << (BF16_EXP_W - 1)) - 1;

  // Quiet NaN: fraction MSB set, all other fraction bits clear.
  localparam logic [BF16_FRAC_W-1:0] BF16_NAN_FRAC = 7'h40;

  // Quotient bits produced: hidden bit, fraction, plus guard and sticky bits.
  localparam int DIV_ITERS = BF16_FRAC_W + 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } div_state_t;

endpackage

// File: rtl/fp_div_special.sv
// Operand classifier for the divider: detects zero/inf/NaN combinations and
// produces the bypass result so they never enter the iterative path.
module fp_div_special
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = BF16_EXP_W,
  parameter int FRAC_WIDTH = BF16_FRAC_W
) (
  input  logic                  op1_sign,
  input  logic [EXP_WIDTH-1:0]  op1_exp,
  input  logic [FRAC_WIDTH-1:0] op1_frac,
  input  logic                  op2_sign,
  input  logic [EXP_WIDTH-1:0]  op2_exp,
  input  logic [FRAC_WIDTH-1:0] op2_frac,
  output logic                  is_special,
  output logic                  sp_sign,
  output logic [EXP_WIDTH-1:0]  sp_exp,
  output logic [FRAC_WIDTH-1:0] sp_frac,
  output logic                  sp_div_by_zero
);

  localparam logic [FRAC_WIDTH-1:0] NAN_FRAC = (FRAC_WIDTH == BF16_FRAC_W) ?
      FRAC_WIDTH'(BF16_NAN_FRAC) : {1'b1, {(FRAC_WIDTH-1){1'b0}}};

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  assign a_zero = (op1_exp == '0);
  assign a_inf  = (op1_exp == '1) && (op1_frac == '0);
  assign a_nan  = (op1_exp == '1) && (op1_frac != '0);
  assign b_zero = (op2_exp == '0);
  assign b_inf  = (op2_exp == '1) && (op2_frac == '0);
  assign b_nan  = (op2_exp == '1) && (op2_frac != '0);

  always_comb begin
    is_special     = 1'b1;
    sp_sign        = op1_sign ^ op2_sign;
    sp_exp         = '0;
    sp_frac        = '0;
    sp_div_by_zero = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_sign = 1'b0;
      sp_exp  = '1;
      sp_frac = NAN_FRAC;
    end else if (a_inf) begin
      sp_exp = '1;
    end else if (b_zero) begin
      sp_exp         = '1;
      sp_div_by_zero = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_exp = '0;
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative bfloat16 divider (restoring, one quotient bit per cycle).
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_div_seq
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = BF16_EXP_W,
  parameter int FRAC_WIDTH = BF16_FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  op1_sign,
  input  logic [EXP_WIDTH-1:0]  op1_exp,
  input  logic [FRAC_WIDTH-1:0] op1_frac,
  input  logic                  op2_sign,
  input  logic [EXP_WIDTH-1:0]  op2_exp,
  input  logic [FRAC_WIDTH-1:0] op2_frac,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  op3_sign,
  output logic [EXP_WIDTH-1:0]  op3_exp,
  output logic [FRAC_WIDTH-1:0] op3_frac,
  output logic                  overflow_o,
  output logic                  div_by_zero_o
);

  localparam int N  = FRAC_WIDTH + (DIV_ITERS - BF16_FRAC_W);
  localparam int CW = $clog2(N);
  localparam int EW = EXP_WIDTH + 2;
  localparam int MW = FRAC_WIDTH + 1;
  localparam int RW = FRAC_WIDTH + 2;
  localparam int BIAS = (EXP_WIDTH == BF16_EXP_W) ? BF16_BIAS : (1 << (EXP_WIDTH - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);

  div_state_t state_reg, state_next;
  logic [CW-1:0]         cnt_reg;
  logic [RW-1:0]         r_reg;
  logic [MW-1:0]         d_reg;
  logic [N-1:0]          q_reg;
  logic signed [EW-1:0]  exp_reg;
  logic                  sign_reg;
  logic                  op3_sign_reg;
  logic [EXP_WIDTH-1:0]  op3_exp_reg;
  logic [FRAC_WIDTH-1:0] op3_frac_reg;
  logic                  ovf_reg, dbz_reg;

  logic                  sp_is_special, sp_sign, sp_dbz;
  logic [EXP_WIDTH-1:0]  sp_exp;
  logic [FRAC_WIDTH-1:0] sp_frac;

  fp_div_special #(
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_special (
    .op1_sign      (op1_sign),
    .op1_exp       (op1_exp),
    .op1_frac      (op1_frac),
    .op2_sign      (op2_sign),
    .op2_exp       (op2_exp),
    .op2_frac      (op2_frac),
    .is_special    (sp_is_special),
    .sp_sign       (sp_sign),
    .sp_exp        (sp_exp),
    .sp_frac       (sp_frac),
    .sp_div_by_zero(sp_dbz)
  );

  logic accept;
  assign accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));

  // One restoring step: remainder always stays below twice the divisor.
  logic          q_bit;
  logic [MW-1:0] r_sub;
  logic [RW-1:0] r_step;
  assign q_bit  = (r_reg >= {1'b0, d_reg});
  assign r_sub  = q_bit ? MW'(r_reg - {1'b0, d_reg}) : r_reg[MW-1:0];
  assign r_step = {r_sub, 1'b0};

  logic                  norm_hi;
  logic [FRAC_WIDTH-1:0] mant;
  logic signed [EW-1:0]  e_pre, e_fin;
  logic [FRAC_WIDTH:0]   mant_rnd;
  logic                  round_inc;
  logic                  res_ovf, res_zero;

  assign norm_hi = q_reg[N-1];
  assign mant    = norm_hi ? q_reg[N-2:2] : q_reg[N-3:1];
  assign e_pre   = norm_hi ? exp_reg : exp_reg - EW'(1);

`ifdef FP_DIV_ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard     = norm_hi ? q_reg[1] : q_reg[0];
  assign sticky    = (norm_hi & q_reg[0]) | (r_reg != '0);
  assign round_inc = guard & (sticky | mant[0]);
`else
  assign round_inc = 1'b0;
`endif

  assign mant_rnd = {1'b0, mant} + (FRAC_WIDTH+1)'(round_inc);
  assign e_fin    = mant_rnd[FRAC_WIDTH] ? e_pre + EW'(1) : e_pre;
  assign res_ovf  = !e_fin[EW-1] && (e_fin >= EXP_MAX);
  assign res_zero = e_fin[EW-1] || (e_fin == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i)                state_next = sp_is_special ? DONE : DIVIDE;
        else if (state_reg == DONE) state_next = IDLE;
      end
      DIVIDE:  if (cnt_reg == CW'(N - 1)) state_next = NORM;
      NORM:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      r_reg        <= '0;
      d_reg        <= '0;
      q_reg        <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      op3_sign_reg <= 1'b0;
      op3_exp_reg  <= '0;
      op3_frac_reg <= '0;
      ovf_reg      <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ovf_reg   <= 1'b0;
      dbz_reg   <= 1'b0;
      if (accept) begin
        if (sp_is_special) begin
          op3_sign_reg <= sp_sign;
          op3_exp_reg  <= sp_exp;
          op3_frac_reg <= sp_frac;
          dbz_reg      <= sp_dbz;
        end else begin
          r_reg    <= {2'b01, op1_frac};
          d_reg    <= {1'b1, op2_frac};
          q_reg    <= '0;
          cnt_reg  <= '0;
          sign_reg <= op1_sign ^ op2_sign;
          exp_reg  <= EW'(op1_exp) - EW'(op2_exp) + BIAS_E;
        end
      end else if (state_reg == DIVIDE) begin
        r_reg   <= r_step;
        q_reg   <= {q_reg[N-2:0], q_bit};
        cnt_reg <= cnt_reg + 1'b1;
      end else if (state_reg == NORM) begin
        op3_sign_reg <= sign_reg;
        if (res_ovf) begin
          op3_exp_reg  <= '1;
          op3_frac_reg <= '0;
          ovf_reg      <= 1'b1;
        end else if (res_zero) begin
          op3_exp_reg  <= '0;
          op3_frac_reg <= '0;
        end else begin
          op3_exp_reg  <= e_fin[EXP_WIDTH-1:0];
          op3_frac_reg <= mant_rnd[FRAC_WIDTH-1:0];
        end
      end
    end
  end

  assign busy_o        = (state_reg == DIVIDE) || (state_reg == NORM);
  assign done_o        = (state_reg == DONE);
  assign op3_sign      = op3_sign_reg;
  assign op3_exp       = op3_exp_reg;
  assign op3_frac      = op3_frac_reg;
  assign overflow_o    = ovf_reg;
  assign div_by_zero_o = dbz_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq at bfloat16 defaults.
module tb_fp_div_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic       busy_o, done_o, op3_sign, overflow_o, div_by_zero_o;
  logic [7:0] op3_exp;
  logic [6:0] op3_frac;
  logic [15:0] res;

  int checks = 0;
  int fails  = 0;

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam logic [15:0] ONE_THIRD = 16'h3EAB;
`else
  localparam logic [15:0] ONE_THIRD = 16'h3EAA;
`endif

  fp_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op1_sign     (a[15]),
    .op1_exp      (a[14:7]),
    .op1_frac     (a[6:0]),
    .op2_sign     (b[15]),
    .op2_exp      (b[14:7]),
    .op2_frac     (b[6:0]),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .op3_sign     (op3_sign),
    .op3_exp      (op3_exp),
    .op3_frac     (op3_frac),
    .overflow_o   (overflow_o),
    .div_by_zero_o(div_by_zero_o)
  );

  assign res = {op3_sign, op3_exp, op3_frac};

  always #5 clk = ~clk;

  // Drive operands with start for one acceptance edge; returns #1 after it.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Latency counts the acceptance cycle as 1; bounded at 64.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_o && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, overflow_o, div_by_zero_o} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, overflow_o, div_by_zero_o});
    end
    checks++;
    if (res !== 16'h0000) begin
      fails++;
      $display("FAIL reset_result: got %h want 0000", res);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_one_third;
    int lat;
    logic [15:0] held;
    launch(16'h3F80, 16'h4040);
    checks++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL third_busy: got %b want 1", busy_o);
    end
    wait_done(lat);
    $display("3F80/4040 -> %h lat %0d", res, lat);
    checks++;
    if (lat !== 12 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL third_latency: got %0d done %b want 12", lat, done_o);
    end
    checks++;
    if (res !== ONE_THIRD) begin
      fails++;
      $display("FAIL third_result: got %h want %h", res, ONE_THIRD);
    end
    checks++;
    if ({busy_o, overflow_o, div_by_zero_o} !== 3'b000) begin
      fails++;
      $display("FAIL third_flags: got %b want 000", {busy_o, overflow_o, div_by_zero_o});
    end
    held = res;
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || res !== ONE_THIRD) begin
      fails++;
      $display("FAIL third_hold: got done %b res %h want 0 %h", done_o, res, ONE_THIRD);
    end
    if (held !== ONE_THIRD) $display("held value differs before hold check");
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(16'h40C0, 16'h4000);
    wait_done(lat);
    $display("40C0/4000 -> %h lat %0d", res, lat);
    checks++;
    if (res !== 16'h4040 || lat !== 12) begin
      fails++;
      $display("FAIL exact_result: got %h lat %0d want 4040 lat 12", res, lat);
    end
    // Launch straight from the done cycle.
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_in_done: got done %b want 1", done_o);
    end
    a = 16'h4000;
    b = 16'h3F80;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got busy %b want 1", busy_o);
    end
    wait_done(lat);
    $display("4000/3F80 -> %h lat %0d", res, lat);
    checks++;
    if (res !== 16'h4000 || lat !== 12) begin
      fails++;
      $display("FAIL b2b_result: got %h lat %0d want 4000 lat 12", res, lat);
    end
  endtask

  task automatic test_overflow_flush;
    int lat;
    launch(16'h7F00, 16'h3F00);
    wait_done(lat);
    $display("7F00/3F00 -> %h ovf %b", res, overflow_o);
    checks++;
    if (res !== 16'h7F80 || overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL overflow: got %h ovf %b want 7F80 ovf 1", res, overflow_o);
    end
    launch(16'h0080, 16'h7F00);
    wait_done(lat);
    $display("0080/7F00 -> %h ovf %b", res, overflow_o);
    checks++;
    if (res !== 16'h0000 || overflow_o !== 1'b0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL flush: got %h ovf %b done %b want 0000 ovf 0 done 1", res, overflow_o, done_o);
    end
  endtask

  task automatic test_specials;
    int lat;
    logic [15:0] va [6] = '{16'hBF80, 16'h0000, 16'h7F80, 16'h3F80, 16'hFF80, 16'h7FC1};
    logic [15:0] vb [6] = '{16'h0000, 16'h0000, 16'h7F80, 16'h7F80, 16'h4000, 16'h3F80};
    logic [15:0] vr [6] = '{16'hFF80, 16'h7FC0, 16'h7FC0, 16'h0000, 16'hFF80, 16'h7FC0};
    logic        vz [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i]);
      wait_done(lat);
      $display("%h/%h -> %h dbz %b lat %0d", va[i], vb[i], res, div_by_zero_o, lat);
      checks++;
      if (res !== vr[i] || div_by_zero_o !== vz[i] || lat !== 1 || overflow_o !== 1'b0) begin
        fails++;
        $display("FAIL special_%0d: got %h dbz %b lat %0d want %h dbz %b lat 1",
                 i, res, div_by_zero_o, lat, vr[i], vz[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int dones;
    launch(16'h3F80, 16'h4040);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if ({busy_o, done_o} !== 2'b00 || res !== 16'h0000) begin
      fails++;
      $display("FAIL abort_state: got busy %b done %b res %h want 0 0 0000", busy_o, done_o, res);
    end
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    $display("abort: done pulses after reset %0d", dones);
    checks++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d pulses want 0", dones);
    end
    launch(16'h3F80, 16'h4040);
    wait_done(lat);
    $display("restart 3F80/4040 -> %h lat %0d", res, lat);
    checks++;
    if (res !== ONE_THIRD || lat !== 12) begin
      fails++;
      $display("FAIL abort_restart: got %h lat %0d want %h lat 12", res, lat, ONE_THIRD);
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    int dones;
    launch(16'h40C0, 16'h4000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 16'h3F80;
    b = 16'h4040;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    a = 16'hBF80;
    b = 16'h0000;
    wait_done(lat);
    $display("busy restart ignored -> %h", res);
    checks++;
    if (res !== 16'h4040 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL busy_ignore: got %h done %b want 4040 done 1", res, done_o);
    end
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    checks++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL busy_extra_done: got %0d pulses want 0", dones);
    end
  endtask

  initial begin
    test_reset;
    test_one_third;
    test_back_to_back;
    test_overflow_flush;
    test_specials;
    test_reset_abort;
    test_start_while_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative bfloat16 divider: op3 = op1 / op2.
- Fills the divide slot of the FPU operation mux, which already exports div operand fields and expects div result and overflow fields.
- Multi-cycle restoring mantissa division with a start/done handshake; special operands bypass the iteration.

Parameters:
- EXP_WIDTH, 8, exponent field width
- FRAC_WIDTH, 7, stored fraction width (hidden bit implicit)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets)
- start_i  in  1  launch request; accepted only when busy_o==0
- op1_sign/op2_sign  in  1  operand signs (op1 dividend, op2 divisor)
- op1_exp/op2_exp  in  EXP_WIDTH  biased exponents
- op1_frac/op2_frac  in  FRAC_WIDTH  fractions
- busy_o  out  1  division in progress
- done_o  out  1  one-cycle pulse; result valid
- op3_sign  out  1  result sign
- op3_exp  out  EXP_WIDTH  result exponent
- op3_frac  out  FRAC_WIDTH  result fraction
- overflow_o  out  1  result overflowed to infinity
- div_by_zero_o  out  1  finite nonzero / zero

Behaviour:
- Reset (rst==0 at an edge): state IDLE; all outputs 0. Reset mid-division aborts; no done_o pulse.
- Operands are sampled into internal registers at acceptance; later changes on the inputs are ignored.
- Number model: exp==0 means zero, no denormals. exp==all-ones with frac==0 is inf; with frac!=0 it is NaN. BIAS=2^(EXP_WIDTH-1)-1.
- States: IDLE -> (start_i, special) -> DONE; IDLE -> (start_i, normal) -> DIVIDE -> NORM -> DONE -> IDLE.
- DIVIDE runs N=FRAC_WIDTH+3 cycles, counted by a counter 0..N-1.
- Latency from the acceptance edge: special cases assert done_o 1 cycle later; normal cases assert done_o N+2 cycles later (12 at defaults).
- busy_o=1 in DIVIDE and NORM; it is 0 in DONE. start_i in DONE is accepted in that same cycle. start_i while busy is ignored.
- Result outputs hold their value until the next done_o.
- Specials, evaluated in priority order; NaN result = sign 0, exp all-ones, frac MSB set (0x7FC0 at defaults):
  - any NaN, 0/0, or inf/inf -> NaN
  - inf/finite -> ±inf
  - finite nonzero/0 -> ±inf, div_by_zero_o=1
  - 0/nonzero or finite/inf -> ±0
- Normal path:
  - sign = s1^s2.
  - Exponent e = e1 - e2 + BIAS, held in EXP_WIDTH+2-bit signed arithmetic.
  - Remainder r = {1,frac1}. Each DIVIDE step: if r >= {1,frac2}, set the q bit and subtract; then shift r left by 1. The N steps produce q[N-1:0] MSB first.
- NORM:
  - if q[N-1]=1: mant=q[N-2:2], guard=q[1], sticky=q[0]|(r!=0)
  - else: mant=q[N-3:1], guard=q[0], sticky=(r!=0), e=e-1
  - Apply rounding (see Optional Feature). A mantissa carry-out sets frac=0 and e=e+1.
  - If e >= 2^EXP_WIDTH-1: result ±inf, overflow_o=1.
  - If e <= 0: flush to ±0, overflow_o=0.
- overflow_o and div_by_zero_o are updated only on result writes and are 0 otherwise.

Optional Feature:
- Macro FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment the mantissa when guard && (sticky || mant[0]).
- Undefined: truncate; guard and sticky are ignored. The iteration count is unchanged, so latency is identical in both builds.

Decomposition:
- Shared package fpu_pkg:
  - BF16 BIAS
  - canonical NaN fraction constant
  - state enum typedef (IDLE, DIVIDE, NORM, DONE)
  - iteration count constant
- One combinational sub-module, fp_div_special. It classifies operands (zero/inf/NaN) and produces the special result, its flags, and an is_special bit.

Test Plan:
- 0x3F80 / 0x4040 (1.0/3.0) -> 0x3EAB with FP_DIV_ROUND_NEAREST_EN; 0x3EAA without it. done_o 12 cycles after acceptance; overflow_o=0.
- 0x40C0 / 0x4000 (6.0/2.0) -> 0x4040, exact. Then back-to-back start_i in the done cycle with 0x4000/0x3F80 -> 0x4000.
- 0x7F00 / 0x3F00 -> 0x7F80, overflow_o=1. Then 0x0080 / 0x7F00 -> 0x0000 (flush), overflow_o=0.
- 0xBF80 / 0x0000 -> 0xFF80, div_by_zero_o=1, done_o 1 cycle after acceptance. 0x0000/0x0000 -> 0x7FC0. 0x7F80/0x7F80 -> 0x7FC0.
- Start 0x3F80/0x4040, pull rst low at cycle 5 -> no done_o, outputs 0. Restart -> correct result.
- start_i pulsed during DIVIDE with other operands -> ignored; the original result is delivered.
